hd_assoc_search: RTL

// - Associative-memory search stage directly downstream of random_index_block.
// - Stores NUMLANG language prototype hypervectors, loaded through a write port.
// - On a query (the text hypervector produced after textDone), computes the Hamming distance to every prototype.
// - Reports the index and distance of the closest prototype.
// - Processes CHUNK bits per cycle to bound popcount width and area.

---
 rtl/hd_assoc_search_if.sv | 38 +++
 rtl/hd_assoc_search.sv | 114 +++++++++++
 2 files changed

// File: rtl/hd_assoc_search_if.sv
// hd_assoc_search_if: prototype-load, query and result bundle for hd_assoc_search.
// With AM_SECOND_BEST_EN defined it also carries the runner-up label and distance.
interface hd_assoc_search_if #(
  parameter int N = 10000,
  parameter int LANG_W = 5,
  parameter int DIST_W = 14
);
  logic protoWe;
  logic [LANG_W-1:0] protoSel;
  logic [N-1:0] protoData;
  logic queryValid;
  logic [N-1:0] queryVector;
  logic busy;
  logic resultValid;
  logic [LANG_W-1:0] bestLang;
  logic [DIST_W-1:0] bestDist;
`ifdef AM_SECOND_BEST_EN
  logic [LANG_W-1:0] secondLang;
  logic [DIST_W-1:0] secondDist;
  modport master (
    output protoWe, protoSel, protoData, queryValid, queryVector,
    input busy, resultValid, bestLang, bestDist, secondLang, secondDist
  );
  modport slave (
    input protoWe, protoSel, protoData, queryValid, queryVector,
    output busy, resultValid, bestLang, bestDist, secondLang, secondDist
  );
`else
  modport master (
    output protoWe, protoSel, protoData, queryValid, queryVector,
    input busy, resultValid, bestLang, bestDist
  );
  modport slave (
    input protoWe, protoSel, protoData, queryValid, queryVector,
    output busy, resultValid, bestLang, bestDist
  );
`endif
endinterface

// File: rtl/hd_assoc_search.sv
// hd_assoc_search: finds the stored prototype nearest to a query in Hamming distance, CHUNK bits per cycle.
// Define AM_SECOND_BEST_EN to also report the runner-up label and distance.
module hd_assoc_search #(
  parameter int N = 10000,
  parameter int NUMLANG = 22,
  parameter int CHUNK = 100,
  parameter int LANG_W = 5,
  parameter int DIST_W = 14
) (
  input logic clk,
  input logic rst,
  hd_assoc_search_if.slave bus
);
  localparam int NCHUNK = N / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (N % CHUNK != 0) begin : gBadChunk
    $error("hd_assoc_search: N must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, CMP, UPD, DONE} state_t;
  state_t state, nextState;
  logic [N-1:0] proto [NUMLANG];
  logic [N-1:0] query;
  logic [LANG_W-1:0] lang, minLang, updLang, bestLang;
  logic [CW-1:0] chunk;
  logic [DIST_W-1:0] acc, minDist, updDist, chunkDist, bestDist;
  logic start, lastChunk, lastLang, newBest, resultValid;
  int base;
  assign start = state == IDLE && bus.queryValid;
  assign lastChunk = chunk == CW'(NCHUNK - 1);
  assign lastLang = lang == LANG_W'(NUMLANG - 1);
  assign base = int'(chunk) * CHUNK;
  assign chunkDist = DIST_W'($countones(query[base +: CHUNK] ^ proto[lang][base +: CHUNK]));
  // Strict compare: on a tie the earlier (lower) index stays best.
  assign newBest = acc < minDist;
  assign updDist = newBest ? acc : minDist;
  assign updLang = newBest ? lang : minLang;
  assign bus.busy = state != IDLE;
  assign bus.resultValid = resultValid;
  assign bus.bestLang = bestLang;
  assign bus.bestDist = bestDist;
`ifdef AM_SECOND_BEST_EN
  logic [LANG_W-1:0] secondIdx, updSecondLang, secondLang;
  logic [DIST_W-1:0] secondMin, updSecondDist, secondDist;
  assign updSecondDist = newBest ? minDist : acc < secondMin ? acc : secondMin;
  assign updSecondLang = newBest ? minLang : acc < secondMin ? lang : secondIdx;
  assign bus.secondLang = secondLang;
  assign bus.secondDist = secondDist;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = state == IDLE ? (bus.queryValid ? CMP : IDLE)
              : state == CMP  ? (lastChunk ? UPD : CMP)
              : state == UPD  ? (lastLang ? DONE : CMP)
              : IDLE;
  // Prototype and query storage are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.protoWe && int'(bus.protoSel) < NUMLANG) proto[bus.protoSel] <= bus.protoData;
    if (start) query <= bus.queryVector;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lang <= '0;
      chunk <= '0;
      acc <= '0;
      minDist <= '1;
      minLang <= '0;
      bestLang <= '0;
      bestDist <= '0;
      resultValid <= 1'b0;
`ifdef AM_SECOND_BEST_EN
      secondMin <= '1;
      secondIdx <= '0;
      secondLang <= '0;
      secondDist <= '0;
`endif
    end else begin
      resultValid <= state == UPD && lastLang;
      if (start) begin
        lang <= '0;
        chunk <= '0;
        acc <= '0;
        minDist <= '1;
        minLang <= '0;
`ifdef AM_SECOND_BEST_EN
        secondMin <= '1;
        secondIdx <= '0;
`endif
      end else if (state == CMP) begin
        acc <= acc + chunkDist;
        chunk <= lastChunk ? '0 : chunk + CW'(1);
      end else if (state == UPD) begin
        minDist <= updDist;
        minLang <= updLang;
`ifdef AM_SECOND_BEST_EN
        secondMin <= updSecondDist;
        secondIdx <= updSecondLang;
`endif
        if (lastLang) begin
          bestLang <= updLang;
          bestDist <= updDist;
`ifdef AM_SECOND_BEST_EN
          secondLang <= updSecondLang;
          secondDist <= updSecondDist;
`endif
        end else begin
          lang <= lang + LANG_W'(1);
          chunk <= '0;
          acc <= '0;
        end
      end
    end
endmodule
